// File: rtl/chr_latch_bank_unit.sv
// PPU-snooping CHR latch engine (MMC2/MMC4 style) with N latch states per pattern-table half.
// Optional per-channel trigger counters: define CHR_LATCH_TRIG_CNT_EN.
module chr_latch_bank_unit #(
  parameter int         STATES    = 2,
  parameter int         BANK_W    = 5,
  parameter logic [7:0] TILE_BASE = 8'hFD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ppu_oe,
  input  logic [13:0]                   ppu_addr,
  input  logic                          exact_mode,
  input  logic                          bank_we,
  input  logic [$clog2(2*STATES)-1:0]   bank_idx,
  input  logic [BANK_W-1:0]             bank_di,
  input  logic                          sst_we,
  input  logic [7:0]                    sst_di,
  output logic [7:0]                    sst_do,
  output logic [3:0]                    latch_q,
  output logic [BANK_W-1:0]             chr_bank
`ifdef CHR_LATCH_TRIG_CNT_EN
  ,
  output logic [15:0]                   trig_cnt
`endif
);

  localparam int NBANK = 2 * STATES;

  logic [3:0]        oe_st_q, oe_st_d;
  logic [13:0]       cap_addr_q, cap_addr_d;
  logic [1:0]        state_q [2];
  logic [1:0]        state_d [2];
  logic [BANK_W-1:0] bank_q [NBANK];
  logic [BANK_W-1:0] bank_d [NBANK];

  logic       fall_det, rise_det;
  logic       trig_hit;
  logic [1:0] trig_k;
  logic       trig_ch;
  logic       addr_ok;
  logic       sst_unused;

  assign sst_unused = ^sst_di[7:4];

  function automatic logic [1:0] clamp_st(input logic [1:0] v);
    if (int'(v) > STATES - 1) return 2'(STATES - 1);
    return v;
  endfunction

  assign fall_det = (oe_st_q == 4'b1000);
  assign rise_det = (oe_st_q == 4'b0001);

  always_comb begin
    oe_st_d    = {oe_st_q[2:0], ppu_oe};
    cap_addr_d = fall_det ? ppu_addr : cap_addr_q;
  end

  // ch0 in exact mode only accepts the first byte of the high bitplane
  always_comb begin
    trig_hit = 1'b0;
    trig_k   = 2'd0;
    trig_ch  = cap_addr_q[12];
    addr_ok  = rise_det && !cap_addr_q[13] && cap_addr_q[3] &&
               (!(exact_mode && !cap_addr_q[12]) || (cap_addr_q[2:0] == 3'd0));
    for (int k = 0; k < STATES; k++) begin
      if (addr_ok && (cap_addr_q[11:4] == 8'(TILE_BASE + 8'(k)))) begin
        trig_hit = 1'b1;
        trig_k   = 2'(k);
      end
    end
  end

  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (sst_we) begin
      state_d[0] = clamp_st(sst_di[1:0]);
      state_d[1] = clamp_st(sst_di[3:2]);
    end else if (trig_hit) begin
      state_d[trig_ch] = trig_k;
    end
  end

  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      bank_d[i] = bank_q[i];
      if (bank_we && (int'(bank_idx) == i)) bank_d[i] = bank_di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_st_q    <= 4'b1111;
      cap_addr_q <= 14'd0;
      state_q[0] <= 2'd0;
      state_q[1] <= 2'd0;
      for (int i = 0; i < NBANK; i++) bank_q[i] <= '0;
    end else begin
      oe_st_q    <= oe_st_d;
      cap_addr_q <= cap_addr_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      for (int i = 0; i < NBANK; i++) bank_q[i] <= bank_d[i];
    end
  end

  always_comb begin
    int sel;
    sel      = (ppu_addr[12] ? STATES : 0) + int'(state_q[ppu_addr[12]]);
    chr_bank = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (sel == i) chr_bank = bank_q[i];
    end
  end

  assign latch_q = {state_q[1], state_q[0]};
  assign sst_do  = {4'd0, state_q[1], state_q[0]};

`ifdef CHR_LATCH_TRIG_CNT_EN
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];

  always_comb begin
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];
    if (sst_we) begin
      cnt_d[0] = 8'd0;
      cnt_d[1] = 8'd0;
    end else if (trig_hit && (cnt_q[trig_ch] != 8'hFF)) begin
      cnt_d[trig_ch] = cnt_q[trig_ch] + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q[0] <= 8'd0;
      cnt_q[1] <= 8'd0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign trig_cnt = {cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_chr_latch_bank_unit.sv
// Self-checking bench for chr_latch_bank_unit: a default (STATES=2) and a STATES=3 instance.
module tb_chr_latch_bank_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        oe_a, exact_a, bwe_a, swe_a;
  logic [13:0] addr_a;
  logic [1:0]  bidx_a;
  logic [4:0]  bdi_a, cb_a;
  logic [7:0]  sdi_a, sdo_a;
  logic [3:0]  lq_a;

  logic        oe_b, exact_b, bwe_b, swe_b;
  logic [13:0] addr_b;
  logic [2:0]  bidx_b;
  logic [4:0]  bdi_b, cb_b;
  logic [7:0]  sdi_b, sdo_b;
  logic [3:0]  lq_b;

`ifdef CHR_LATCH_TRIG_CNT_EN
  logic [15:0] tc_a, tc_b;
`endif

  chr_latch_bank_unit #(.STATES(2), .BANK_W(5), .TILE_BASE(8'hFD)) u_a (
    .clk(clk), .rst(rst), .ppu_oe(oe_a), .ppu_addr(addr_a), .exact_mode(exact_a),
    .bank_we(bwe_a), .bank_idx(bidx_a), .bank_di(bdi_a), .sst_we(swe_a), .sst_di(sdi_a),
    .sst_do(sdo_a), .latch_q(lq_a), .chr_bank(cb_a)
`ifdef CHR_LATCH_TRIG_CNT_EN
    , .trig_cnt(tc_a)
`endif
  );

  chr_latch_bank_unit #(.STATES(3), .BANK_W(5), .TILE_BASE(8'hFD)) u_b (
    .clk(clk), .rst(rst), .ppu_oe(oe_b), .ppu_addr(addr_b), .exact_mode(exact_b),
    .bank_we(bwe_b), .bank_idx(bidx_b), .bank_di(bdi_b), .sst_we(swe_b), .sst_di(sdi_b),
    .sst_do(sdo_b), .latch_q(lq_b), .chr_bank(cb_b)
`ifdef CHR_LATCH_TRIG_CNT_EN
    , .trig_cnt(tc_b)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [15:0] exp_q[$];
  logic [4:0]  cb_mid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    if (exp_q.size() == 0) chk(tag, obs, 16'hxxxx);
    else chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic look(input bit b, input logic [13:0] a);
    tick();
    if (b) addr_b = a; else addr_a = a;
    #1;
  endtask

  task automatic wbank(input bit b, input int idx, input logic [4:0] v);
    tick();
    if (b) begin bwe_b = 1'b1; bidx_b = 3'(idx); bdi_b = v; end
    else   begin bwe_a = 1'b1; bidx_a = 2'(idx); bdi_a = v; end
    tick();
    bwe_a = 1'b0; bwe_b = 1'b0;
  endtask

  task automatic sst(input bit b, input logic [7:0] v);
    tick();
    if (b) begin swe_b = 1'b1; sdi_b = v; end
    else   begin swe_a = 1'b1; sdi_a = v; end
    tick();
    swe_a = 1'b0; swe_b = 1'b0;
  endtask

  // returns after the state update; cb_mid holds chr_bank in the rise-detect cycle
  task automatic fetch(input bit b, input logic [13:0] a, input int n, output logic [4:0] mid);
    tick();
    if (b) begin addr_b = a; oe_b = 1'b0; end
    else   begin addr_a = a; oe_a = 1'b0; end
    repeat (n) tick();
    oe_a = 1'b1; oe_b = 1'b1;
    tick();
    mid = b ? cb_b : cb_a;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    oe_a = 1'b1; addr_a = '0; exact_a = 1'b0; bwe_a = 1'b0; bidx_a = '0; bdi_a = '0;
    swe_a = 1'b0; sdi_a = '0;
    oe_b = 1'b1; addr_b = '0; exact_b = 1'b0; bwe_b = 1'b0; bidx_b = '0; bdi_b = '0;
    swe_b = 1'b0; sdi_b = '0;
    repeat (3) tick();
    push(16'h0); pop_chk("rst_latch", {12'd0, lq_a});
    push(16'h0); pop_chk("rst_cb",    {11'd0, cb_a});
    push(16'h0); pop_chk("rst_sst",   {8'd0, sdo_a});
    rst = 1'b0;

    wbank(0, 0, 5'h03);
    fetch(0, 14'h0FD8, 6, cb_mid);
    push(16'h0); pop_chk("fd_latch0", {12'd0, lq_a});
    look(0, 14'h0123);
    push(16'h03); pop_chk("cb_0123", {11'd0, cb_a});

    wbank(0, 1, 5'h11);
    fetch(0, 14'h0FE8, 6, cb_mid);
    push(16'h03); pop_chk("fe_old_bank", {11'd0, cb_mid});
    push(16'h1);  pop_chk("fe_latch1", {12'd0, lq_a});
    look(0, 14'h0000);
    push(16'h11); pop_chk("cb_0000_b1", {11'd0, cb_a});

    wbank(0, 2, 5'h07);
    wbank(0, 3, 5'h1A);
    fetch(0, 14'h1FE8, 6, cb_mid);
    push(16'h5); pop_chk("ch1_fe", {12'd0, lq_a});
    look(0, 14'h1000);
    push(16'h1A); pop_chk("cb_1000_b3", {11'd0, cb_a});

    exact_a = 1'b1;
    fetch(0, 14'h0FDA, 6, cb_mid);
    push(16'h5); pop_chk("exact_ch0_miss", {12'd0, lq_a});
    fetch(0, 14'h1FDA, 6, cb_mid);
    push(16'h1); pop_chk("exact_ch1_win", {12'd0, lq_a});
    exact_a = 1'b0;
    fetch(0, 14'h0FDA, 6, cb_mid);
    push(16'h0); pop_chk("window_ch0", {12'd0, lq_a});

    fetch(0, 14'h1FE8, 2, cb_mid);
    repeat (2) tick();
    push(16'h0); pop_chk("short_pulse", {12'd0, lq_a});
    fetch(0, 14'h2FE8, 8, cb_mid);
    push(16'h0); pop_chk("nametable", {12'd0, lq_a});
    fetch(0, 14'h0FE8, 3, cb_mid);
    push(16'h1); pop_chk("min_pulse3", {12'd0, lq_a});

    sst(0, 8'h0F);
    push(16'h5);  pop_chk("sst_clamp", {12'd0, lq_a});
    push(16'h05); pop_chk("sst_do", {8'd0, sdo_a});
    sst(0, 8'h04);
    push(16'h4);  pop_chk("sst_fields", {12'd0, lq_a});

    for (int i = 0; i < 6; i++) wbank(1, i, 5'(5'h10 + i));
    wbank(1, 6, 5'h1F);
    wbank(1, 7, 5'h1E);
    fetch(1, 14'h1FF8, 6, cb_mid);
    push(16'h8);  pop_chk("b_ff_latch", {12'd0, lq_b});
    push(16'h15); pop_chk("b_cb_bank5", {11'd0, cb_b});
    fetch(1, 14'h0FE8, 6, cb_mid);
    push(16'h9);  pop_chk("b_fe_latch", {12'd0, lq_b});
    look(1, 14'h0000);
    push(16'h11); pop_chk("b_cb_bank1", {11'd0, cb_b});
    sst(1, 8'h0F);
    push(16'hA);  pop_chk("b_sst_clamp", {12'd0, lq_b});
    push(16'h0A); pop_chk("b_sst_do", {8'd0, sdo_b});
    look(1, 14'h0000);
    push(16'h12); pop_chk("b_cb_bank2", {11'd0, cb_b});
    sst(1, 8'h00);
    look(1, 14'h0000);
    push(16'h10); pop_chk("b_bank0_intact", {11'd0, cb_b});

    // A holds state 4'b0100 from the last restore; reset lands mid-fetch
    wbank(0, 0, 5'h09);
    tick();
    addr_a = 14'h0FE8; oe_a = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    push(16'h0); pop_chk("midrst_latch", {12'd0, lq_a});
    push(16'h0); pop_chk("midrst_cb", {11'd0, cb_a});
    tick();
    rst = 1'b0;
    tick();
    oe_a = 1'b1;
    repeat (3) tick();
    push(16'h0); pop_chk("post_rst_rise", {12'd0, lq_a});

`ifdef CHR_LATCH_TRIG_CNT_EN
    for (int i = 0; i < 300; i++) fetch(0, 14'h0FD8, 3, cb_mid);
    push(16'h00FF); pop_chk("cnt_sat", tc_a);
    sst(0, 8'h00);
    push(16'h0000); pop_chk("cnt_clr", tc_a);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/chr_latch_bank_unit.md
Name: chr_latch_bank_unit

Overview:
- Parametrised PPU-snooping CHR latch engine for MMC2/MMC4-class mappers, generalised to N latch states per pattern-table half.
- Two channels:
  - ch0 covers PPU $0000-$0FFF.
  - ch1 covers PPU $1000-$1FFF.
- Each channel holds STATES bank registers. A PPU fetch of trigger tile TILE_BASE+k in that half selects bank k for that channel.
- Sits inside the mapper wrapper: CPU decode drives the bank write port, the PPU bus is snooped on clk, and chr_bank drives chr.addr[BANK_W+11:12].

Parameters:
- STATES, 2, latch states per channel (2..4); default reproduces MMC2/MMC4.
- BANK_W, 5, width of each 4KB CHR bank register (5..8).
- TILE_BASE, 8'hFD, tile ID that selects state 0; state k uses TILE_BASE+k; TILE_BASE+STATES-1 must be ≤ 8'hFF.

Ports:
- clk  in  1  mapper system clock (mai.clk domain).
- rst  in  1  reset, asynchronous, active-high.
- ppu_oe  in  1  PPU read strobe, active low, asynchronous to clk.
- ppu_addr  in  14  PPU address bus.
- exact_mode  in  1  0 = MMC4 window (row 8-15 of tile, both channels); 1 = MMC2 (ch0 matches only byte offset 8, ch1 uses window).
- bank_we  in  1  one-clk write strobe from CPU decode.
- bank_idx  in  $clog2(2*STATES)  register index; ch*STATES+k.
- bank_di  in  BANK_W  bank value.
- sst_we  in  1  save-state latch restore strobe.
- sst_di  in  8  restore data: bits[1:0] = ch0 state, bits[3:2] = ch1 state.
- sst_do  out  8  {4'd0, ch1 state[1:0], ch0 state[1:0]}.
- latch_q  out  4  {ch1 state, ch0 state}, 2 bits each, zero-extended.
- chr_bank  out  BANK_W  bank for current ppu_addr, combinational.

Behaviour:
- Reset (async, rst=1):
  - all bank registers = 0; both channel states = 0; oe shift register = 4'b1111; captured address = 0.
  - Consequence: chr_bank = 0, latch_q = 0, sst_do = 0.
- chr_bank = bank[ppu_addr[12]*STATES + state[ppu_addr[12]]]. Purely combinational, zero clk latency.
- Strobe synchroniser:
  - oe_st[3:0] shifts ppu_oe in at LSB every clk.
  - Fall detect: oe_st == 4'b1000. Then capture ppu_addr[13:0] into cap_addr.
  - Rise detect: oe_st == 4'b0001. Then evaluate the trigger using cap_addr.
  - Pulses shorter than 3 clk are ignored (no capture, no update).
- Trigger match, evaluated on rise detect with k in 0..STATES-1:
  - Requires cap_addr[13] = 0, cap_addr[11:4] = TILE_BASE+k, and cap_addr[3] = 1.
  - If exact_mode = 1 and cap_addr[12] = 0, it additionally requires cap_addr[2:0] = 0.
  - On match: state[cap_addr[12]] <= k.
  - No match: states unchanged.
- State update lands one clk after rise detect. The triggering fetch itself is always served by the old bank (MMC2 semantics).
- Bank writes: on bank_we, bank[bank_idx] <= bank_di, visible on chr_bank the next clk.
  - bank_idx ≥ 2*STATES: write ignored.
- Save-state restore: on sst_we, state[0] <= sst_di[1:0] and state[1] <= sst_di[3:2], each clamped to STATES-1 when larger.
  - sst_we has priority over a coincident trigger update; the trigger is dropped.
- bank_we and a trigger on the same clk: both take effect, no interaction.
- rst asserted mid-fetch: everything clears immediately. A rise after reset release with oe_st not yet at 4'b0001 produces no update.
- Nametable fetches (addr[13] = 1) never trigger.

Optional Feature:
- CHR_LATCH_TRIG_CNT_EN
  - When defined: one 8-bit saturating counter per channel, incremented on each applied trigger (count on match even if the state is unchanged). Reset to 0 by rst; cleared by sst_we.
  - Counters are exposed as out port trig_cnt [15:0] = {ch1, ch0}. Saturates at 8'hFF.
  - When undefined: port and counters absent; no other behaviour change.

Test Plan:
- Reset, then fetch $0FD8 with an oe low pulse of 6 clk -> 1 clk after rise, latch_q[1:0] = 0; bank[0] = 5'h03 drives chr_bank = 5'h03 for ppu_addr $0123.
- bank[1] = 5'h11, fetch $0FE8 -> chr_bank still bank0 during that fetch; 1 clk after rise, latch_q[1:0] = 1 and chr_bank = 5'h11 at $0000.
- exact_mode = 1, fetch $0FDA -> no change. Fetch $1FDA -> latch_q[3:2] = 0. Same with exact_mode = 0 -> ch0 also updates.
- oe low pulse of 2 clk at $1FE8 -> no state change; $2FE8 (nametable) with a long pulse -> no change.
- STATES = 3: fetch $1FF8 -> latch_q[3:2] = 2, chr_bank = bank[5] at $1xxx. sst_we with sst_di = 8'h0F -> both states clamp to 2. bank_idx = 6 write ignored.
- CHR_LATCH_TRIG_CNT_EN: 300 triggers on ch0 -> trig_cnt[7:0] = 8'hFF, ch1 = 0; sst_we -> both 0.
